imem_loader: RTL

Boot-time program loader: the write-side counterpart to the CPU's instruction fetch path. Receives a framed little-endian byte stream, packs it into 32-bit words, and writes them sequentially into the instruction BRAM through its write port (`write_en` / `addr` / `write_data`). Holds the CPU pipeline in reset until a complete frame with a valid checksum has been loaded. Sits beside `Top_CPU`, driving its reset and the IMEM write port.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_word_packer.sv | 35 +++
 rtl/imem_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and frame-field widths for the boot-time IMEM loader.
// Latency and backpressure are properties of imem_loader and word_packer.
package imem_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;

  localparam logic [BYTE_W-1:0] MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs little-endian bytes into 32-bit words; word_full/word_dat are combinational
// with the 4th accepted byte. No backpressure: the caller gates byte_vld.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_dat,
  input  logic              clr,
  output logic [WORD_W-1:0] word_dat,
  output logic              word_full
);

  logic [1:0]  idx;
  logic [23:0] sh;

  // Earlier bytes shift down so the first byte ends up in the low lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      sh  <= '0;
    end else if (clr) begin
      idx <= '0;
      sh  <= '0;
    end else if (byte_vld) begin
      idx <= idx + 2'd1;
      sh  <= {byte_dat, sh[23:8]};
    end
  end

  assign word_full = byte_vld && (idx == 2'd3);
  assign word_dat  = {byte_dat, sh};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader into IMEM; holds the CPU in reset until a checksummed frame lands.
// Write issues 1 cycle after a word's 4th byte; rx_ready drops during that write cycle.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W = 10,
  parameter logic [BYTE_W-1:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int             MAX_WORDS = 2**ADDR_W;
  localparam logic [LEN_W:0] MAX_LEN   = (LEN_W+1)'(MAX_WORDS);

  state_t              state, state_nxt;
  logic                ready_en;
  logic                rx_acc;
  logic                frame_start;
  logic                word_full;
  logic                last_word;
  logic [WORD_W-1:0]   word_dat;
  logic [BYTE_W-1:0]   len_lo;
  logic [BYTE_W-1:0]   csum;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    len_in;
  logic [ADDR_W:0]     word_cnt;

  assign rx_acc      = rx_valid && rx_ready;
  assign len_in      = {rx_data, len_lo};
  assign last_word   = (LEN_W'(word_cnt) == len - LEN_W'(1));
  assign frame_start = rx_acc && (rx_data == MAGIC) &&
                       (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .byte_vld  (rx_acc && (state == ST_DATA)),
    .byte_dat  (rx_data),
    .clr       (frame_start),
    .word_dat  (word_dat),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (frame_start) state_nxt = ST_LEN_LO;
      ST_LEN_LO: if (rx_acc) state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (rx_acc) begin
          if ({1'b0, len_in} > MAX_LEN) state_nxt = ST_ERR;
          else if (len_in == '0)        state_nxt = ST_CHK;
          else                          state_nxt = ST_DATA;
        end
      end
      ST_DATA: if (rx_acc && word_full && last_word) state_nxt = ST_CHK;
      ST_CHK: begin
        if (rx_acc) state_nxt = (rx_data == csum) ? ST_DONE : ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_rst   = (state != ST_DONE);
    load_done = (state == ST_DONE);
    load_err  = (state == ST_ERR);
    rx_ready  = ready_en && !imem_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      len_lo     <= '0;
      len        <= '0;
      csum       <= '0;
      word_cnt   <= '0;
    end else begin
      ready_en <= 1'b1;
      imem_we  <= rx_acc && (state == ST_DATA) && word_full;
      if (frame_start) begin
        csum     <= '0;
        word_cnt <= '0;
      end
      if (rx_acc && state == ST_LEN_LO) len_lo <= rx_data;
      if (rx_acc && state == ST_LEN_HI) len    <= len_in;
      if (rx_acc && state == ST_DATA) begin
        csum <= csum ^ rx_data;
        if (word_full) begin
          imem_addr  <= word_cnt[ADDR_W-1:0];
          imem_wdata <= word_dat;
          word_cnt   <= word_cnt + 1'b1;
        end
      end
    end
  end

endmodule
